// File: rtl/stream_demux3_pkg.sv
// rtl/stream_demux3_pkg.sv - shared destination encoding and decode for the 1-to-3 stream demux
// Contents:
//   SEL_W       width of the per-beat select field
//   dst_e       destination of a beat (alpha, beta, gamma or drop)
//   decode_dst  (cs, sel) -> dst_e; deselected beats and sel = 3 both drop
package stream_demux3_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    DST_ALPHA = 2'd0,
    DST_BETA  = 2'd1,
    DST_GAMMA = 2'd2,
    DST_DROP  = 2'd3
  } dst_e;

  function automatic dst_e decode_dst(input logic cs, input logic [SEL_W-1:0] sel);
    if (!cs || sel == 2'd3) begin
      return DST_DROP;
    end
    return dst_e'(sel);
  endfunction

endpackage

// File: rtl/stream_demux3_demux_slot.sv
// rtl/stream_demux3_demux_slot.sv - one-entry valid/data output register with same-cycle replace
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   load, load_data   write a new beat into the slot on the next edge
//   ready             downstream consumer takes the slot contents this cycle
//   valid, data       registered slot state driven to the channel
//   free              slot can take a beat this cycle (empty or draining)
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  assign free = !valid || ready;

  // A load wins over a drain: when both happen on one edge the old beat
  // leaves and the new one takes its place, so valid stays high.
  // Data is deliberately left alone on a pure drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux3.sv
// rtl/stream_demux3.sv - registered 1-to-3 stream demultiplexer with saturating drop counter
// Ports:
//   clk, reset                   clock and asynchronous active-high reset
//   in_valid/in_ready/in_data    input stream handshake and payload
//   in_sel, in_cs                per-beat destination select and chip select
//   alpha/beta/gamma (+_valid, _ready)  buffered output channels
//   drop_count                   saturating count of discarded beats
//   busy                         any channel currently holds a beat
module stream_demux3
  import stream_demux3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_cs,
  output logic             alpha_valid,
  input  logic             alpha_ready,
  output logic [WIDTH-1:0] alpha,
  output logic             beta_valid,
  input  logic             beta_ready,
  output logic [WIDTH-1:0] beta,
  output logic             gamma_valid,
  input  logic             gamma_ready,
  output logic [WIDTH-1:0] gamma,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  dst_e dst;
  logic alpha_free, beta_free, gamma_free;
  logic fire;
  logic alpha_load, beta_load, gamma_load;
  logic drop_fire;

  assign dst = decode_dst(in_cs, in_sel);

  // in_ready looks only at the destination slot, never at in_valid, so a
  // stalled beat waits at the input without blocking the other channels.
  always_comb begin
    in_ready = 1'b1;
    case (dst)
      DST_ALPHA: in_ready = alpha_free;
      DST_BETA:  in_ready = beta_free;
      DST_GAMMA: in_ready = gamma_free;
      DST_DROP:  in_ready = 1'b1;
      default:   in_ready = 1'b1;
    endcase
  end

  assign fire       = in_valid && in_ready;
  assign alpha_load = fire && (dst == DST_ALPHA);
  assign beta_load  = fire && (dst == DST_BETA);
  assign gamma_load = fire && (dst == DST_GAMMA);
  assign drop_fire  = fire && (dst == DST_DROP);

  demux_slot #(.WIDTH(WIDTH)) u_alpha (
    .clk(clk), .reset(reset), .load(alpha_load), .load_data(in_data),
    .ready(alpha_ready), .valid(alpha_valid), .data(alpha), .free(alpha_free)
  );

  demux_slot #(.WIDTH(WIDTH)) u_beta (
    .clk(clk), .reset(reset), .load(beta_load), .load_data(in_data),
    .ready(beta_ready), .valid(beta_valid), .data(beta), .free(beta_free)
  );

  demux_slot #(.WIDTH(WIDTH)) u_gamma (
    .clk(clk), .reset(reset), .load(gamma_load), .load_data(in_data),
    .ready(gamma_ready), .valid(gamma_valid), .data(gamma), .free(gamma_free)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_fire && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  // busy is registered from the slots' next-state valids so that it tracks
  // the channel valids exactly while still coming straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= alpha_load || (alpha_valid && !alpha_ready) ||
              beta_load  || (beta_valid  && !beta_ready)  ||
              gamma_load || (gamma_valid && !gamma_ready);
    end
  end

endmodule

// File: tb/tb_stream_demux3.sv
// tb/tb_stream_demux3.sv - scoreboard bench for stream_demux3
module tb_stream_demux3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_cs;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       alpha_valid, alpha_ready, beta_valid, beta_ready, gamma_valid, gamma_ready;
  logic [7:0] alpha, beta, gamma, drop_count;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qg[$];
  int         mdrop = 0;

  always #5 clk = ~clk;

  stream_demux3 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_cs(in_cs),
    .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha(alpha),
    .beta_valid(beta_valid), .beta_ready(beta_ready), .beta(beta),
    .gamma_valid(gamma_valid), .gamma_ready(gamma_ready), .gamma(gamma),
    .drop_count(drop_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks DUT against the model at the falling edge, then advances the model
  // by whatever handshakes complete on the coming rising edge.
  task automatic cycle();
    int  d;
    logic exp_ready;
    @(negedge clk);
    d = (in_cs && in_sel != 2'd3) ? int'(in_sel) : 3;
    case (d)
      0:       exp_ready = (qa.size() == 0) || alpha_ready;
      1:       exp_ready = (qb.size() == 0) || beta_ready;
      2:       exp_ready = (qg.size() == 0) || gamma_ready;
      default: exp_ready = 1'b1;
    endcase
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("alpha_valid", {31'd0, alpha_valid}, {31'd0, qa.size() != 0});
    if (qa.size() != 0) chk("alpha_data", {24'd0, alpha}, {24'd0, qa[0]});
    chk("beta_valid", {31'd0, beta_valid}, {31'd0, qb.size() != 0});
    if (qb.size() != 0) chk("beta_data", {24'd0, beta}, {24'd0, qb[0]});
    chk("gamma_valid", {31'd0, gamma_valid}, {31'd0, qg.size() != 0});
    if (qg.size() != 0) chk("gamma_data", {24'd0, gamma}, {24'd0, qg[0]});
    chk("busy", {31'd0, busy}, {31'd0, (qa.size() + qb.size() + qg.size()) != 0});
    chk("drop_count", {24'd0, drop_count}, mdrop);
    if (qa.size() != 0 && alpha_ready) void'(qa.pop_front());
    if (qb.size() != 0 && beta_ready)  void'(qb.pop_front());
    if (qg.size() != 0 && gamma_ready) void'(qg.pop_front());
    if (in_valid && exp_ready) begin
      case (d)
        0:       qa.push_back(in_data);
        1:       qb.push_back(in_data);
        2:       qg.push_back(in_data);
        default: if (mdrop != 255) mdrop++;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic cs, input logic [1:0] sel, input logic [7:0] data);
    in_valid = 1'b1;
    in_cs    = cs;
    in_sel   = sel;
    in_data  = data;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_cs    = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    qa.delete();
    qb.delete();
    qg.delete();
    mdrop = 0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    alpha_ready = 1'b1;
    beta_ready  = 1'b1;
    gamma_ready = 1'b1;
    #12;
    chk("rst_alpha_valid", {31'd0, alpha_valid}, 0);
    chk("rst_beta_valid", {31'd0, beta_valid}, 0);
    chk("rst_gamma_valid", {31'd0, gamma_valid}, 0);
    chk("rst_alpha", {24'd0, alpha}, 0);
    chk("rst_beta", {24'd0, beta}, 0);
    chk("rst_gamma", {24'd0, gamma}, 0);
    chk("rst_drop", {24'd0, drop_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    do_reset();

    // single alpha beat, latency one cycle, then drains
    beat(1'b1, 2'd0, 8'hA5);
    cycle();
    idle();
    chk("alpha_lat_valid", {31'd0, alpha_valid}, 1);
    chk("alpha_lat_data", {24'd0, alpha}, 8'hA5);
    cycle();
    chk("alpha_drained", {31'd0, alpha_valid}, 0);
    cycle();

    // preload gamma with gamma stalled, then stall beta with a pending beat
    gamma_ready = 1'b0;
    beta_ready  = 1'b0;
    beat(1'b1, 2'd2, 8'h33);
    cycle();
    beat(1'b1, 2'd1, 8'h11);
    cycle();
    beat(1'b1, 2'd1, 8'h22);
    cycle();
    cycle();
    chk("beta_stall_ready", {31'd0, in_ready}, 0);
    chk("beta_stable", {24'd0, beta}, 8'h11);
    gamma_ready = 1'b1;
    cycle();
    gamma_ready = 1'b0;
    chk("gamma_drained", {31'd0, gamma_valid}, 0);
    chk("beta_not_reordered", {24'd0, beta}, 8'h11);
    beta_ready = 1'b1;
    cycle();
    beta_ready = 1'b0;
    idle();
    chk("beta_replaced", {24'd0, beta}, 8'h22);
    chk("beta_still_valid", {31'd0, beta_valid}, 1);
    cycle();
    beta_ready  = 1'b1;
    gamma_ready = 1'b1;
    cycle();
    cycle();

    // drops: sel 3 and cs low
    beat(1'b1, 2'd3, 8'h55);
    cycle();
    beat(1'b0, 2'd1, 8'h7E);
    cycle();
    idle();
    chk("drop_two", {24'd0, drop_count}, 2);
    chk("drop_no_beta", {31'd0, beta_valid}, 0);
    cycle();

    // back-to-back gamma
    for (int i = 1; i <= 4; i++) begin
      beat(1'b1, 2'd2, i[7:0]);
      cycle();
      chk("b2b_gamma", {24'd0, gamma}, i);
    end
    idle();
    cycle();
    cycle();

    // saturation
    for (int i = 0; i < 300; i++) begin
      beat(i[0], 2'd3, i[7:0]);
      cycle();
    end
    idle();
    chk("drop_sat", {24'd0, drop_count}, 255);
    cycle();

    // async reset mid-stream
    do_reset();
    alpha_ready = 1'b0;
    beta_ready  = 1'b0;
    beat(1'b1, 2'd0, 8'h5A);
    cycle();
    beat(1'b1, 2'd1, 8'hB4);
    cycle();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 2'd3, 8'h00);
      cycle();
    end
    idle();
    cycle();
    chk("pre_rst_drop", {24'd0, drop_count}, 5);
    chk("pre_rst_alpha", {31'd0, alpha_valid}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_alpha_valid", {31'd0, alpha_valid}, 0);
    chk("async_beta_valid", {31'd0, beta_valid}, 0);
    chk("async_alpha", {24'd0, alpha}, 0);
    chk("async_beta", {24'd0, beta}, 0);
    chk("async_drop", {24'd0, drop_count}, 0);
    chk("async_busy", {31'd0, busy}, 0);
    do_reset();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_demux3.md
Name: stream_demux3

Overview:
- Registered 1-to-3 demultiplexer, the distribution counterpart of the team's 3-input async select mux (alpha/beta/gamma, sel, cs).
- Accepts one 8-bit input stream with a per-beat select and chip-select.
- Routes each beat into one of three buffered output channels (alpha, beta, gamma), each with its own valid/ready handshake.
- Beats with cs low or sel = 3 are consumed, discarded and counted.

Parameters:
- WIDTH, 8, data width of the input and of each channel.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts the beat this cycle
- in_data  input  WIDTH  input payload
- in_sel  input  2  destination: 0 = alpha, 1 = beta, 2 = gamma, 3 = drop
- in_cs  input  1  chip select; 0 means drop regardless of in_sel
- alpha_valid / beta_valid / gamma_valid  output  1 each  channel register holds data
- alpha_ready / beta_ready / gamma_ready  input  1 each  consumer takes the channel data
- alpha / beta / gamma  output  WIDTH each  channel data, driven from registers
- drop_count  output  CNT_W  number of dropped beats, saturating
- busy  output  1  OR of the three channel valids

Behaviour:
- Reset (async assert, sync-safe deassert by the system): all x_valid = 0, alpha/beta/gamma = 0, drop_count = 0.
  - in_ready is combinational and is valid during reset per the rules below.
- Accept: a transfer occurs when in_valid & in_ready.
- Destination decode (combinational, per beat):
  - dst = DROP if in_cs = 0 or in_sel = 3.
  - Otherwise dst = in_sel.
- Channel x is "free" when x_valid = 0 or x_ready = 1 (same-cycle drain permitted).
- in_ready:
  - dst = DROP: 1.
  - Otherwise: free(dst).
  - in_ready never depends on in_valid.
- Routed transfer:
  - On the next edge, dst register loads in_data and x_valid goes to 1.
  - Latency is 1 cycle: data is visible on the channel the cycle after acceptance.
- Drain: when x_valid & x_ready and no new load for x in the same edge, x_valid goes to 0. Data holds its last value; it is not cleared.
- Simultaneous drain and load on the same channel: the new data replaces the old, x_valid stays 1, and no beat is lost. Full throughput is 1 beat/cycle per channel.
- Backpressure:
  - If dst channel is full and not draining, in_ready = 0 and nothing changes.
  - Other channels continue to drain independently.
  - No head-of-line reordering: the input beat waits.
- Channel stability: while x_valid = 1 and x_ready = 0, the channel data must hold stable.
- Drop transfer:
  - drop_count increments by 1, saturating at 2^CNT_W - 1. No wrap.
  - No channel state changes.
- Channels are fully independent. Any combination of the three may drain in one cycle.
- Reset asserted mid-operation: buffered beats are discarded, the count clears, and outputs return to their reset values immediately (async).
- Output drive: all outputs except in_ready come straight from registers.

Decomposition:
- Package stream_demux3_pkg:
  - enum dst_e {DST_ALPHA = 0, DST_BETA = 1, DST_GAMMA = 2, DST_DROP = 3}.
  - Localparam SEL_W = 2.
  - Decode function (cs, sel) -> dst_e, shared with the mux bench.
- One natural sub-module, demux_slot: a one-entry valid/data register with load, drain, free, and same-cycle replace. Instantiated three times.
- The drop counter and in_ready logic live in the top level.

Test Plan:
- Reset, then in_cs = 1, in_sel = 0, in_data = 0xA5, one beat with alpha_ready = 1 -> in_ready = 1; next cycle alpha_valid = 1, alpha = 0xA5; the following cycle alpha_valid = 0.
- beta_ready held 0, send 0x11 then 0x22 to sel = 1 -> first accepted; second stalls with in_ready = 0 and beta = 0x11 stable; after raising beta_ready for 1 cycle, 0x22 is accepted and beta = 0x22.
- beta stalled full with a beat pending; meanwhile gamma_ready = 1 -> gamma continues to drain normally; pending beta beat is not reordered.
- Drops: beats with sel = 3 (cs = 1) and with cs = 0, sel = 1 (data 0x7E) -> in_ready = 1, no channel goes valid, drop_count = 2.
- Saturation: 300 consecutive drop beats with CNT_W = 8 -> drop_count = 255 and holds.
- Back-to-back: 4 beats to gamma, sel = 2, data 0x01–0x04, gamma_ready = 1 throughout -> gamma shows 0x01..0x04 on consecutive cycles, in_ready stays 1.
- Async reset asserted mid-stream with alpha/beta valid and drop_count = 5 -> all valids = 0 and drop_count = 0 without waiting for a clock edge.
